// File: rtl/cve2_sleep_ctrl.sv
// Core sleep / clock-enable controller: OFF/RUN/IDLE/SLEEP FSM with idle hysteresis,
// maskable wake sources with cause capture, optional drain-before-halt and a sleep counter.
module cve2_sleep_ctrl #(
  parameter int unsigned NumWakeSrc    = 4,
  parameter int unsigned IdleCycles    = 4,
  parameter bit          StickyFetchEn = 1'b1,
  parameter int unsigned CntWidth      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  fetch_enable_i,
  input  logic                  core_busy_i,
  input  logic [NumWakeSrc-1:0] wake_i,
  input  logic [NumWakeSrc-1:0] wake_mask_i,
  input  logic                  debug_req_i,
  input  logic                  irq_nm_i,
  output logic                  clk_en_o,
  output logic                  fetch_enable_o,
  output logic                  core_sleep_o,
  output logic [1:0]            sleep_state_o,
  output logic                  wake_valid_o,
  output logic [NumWakeSrc+1:0] wake_cause_o,
  output logic [CntWidth-1:0]   sleep_cycles_o
);

  typedef enum logic [1:0] {OFF = 2'd0, RUN = 2'd1, IDLE = 2'd2, SLEEP = 2'd3} state_e;

  localparam int unsigned IW       = (IdleCycles > 1) ? $clog2(IdleCycles) : 1;
  localparam int unsigned IdleLoadI = (IdleCycles == 0) ? 0 : IdleCycles - 1;
  localparam logic [IW-1:0] IdleLoad = IW'(IdleLoadI);

  state_e                  state_q, state_d;
  logic [IW-1:0]           idle_q, idle_d;
  logic                    halt_q, fe_q, wv_q;
  logic [NumWakeSrc+1:0]   cause_q;
  logic [CntWidth-1:0]     cnt_q;
  logic                    wake_any, is_idle, drain_off, wake_exit;

  assign wake_any  = (|(wake_i & wake_mask_i)) | debug_req_i | irq_nm_i;
  assign is_idle   = ~core_busy_i & ~wake_any;
  // A pending halt preempts every other transition once the core has drained.
  assign drain_off = (state_q != OFF) & halt_q & ~core_busy_i;
  assign wake_exit = (state_q == SLEEP) & (state_d == RUN);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= OFF;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    if (drain_off) begin
      state_d = OFF;
    end else begin
      unique case (state_q)
        OFF: if (fetch_enable_i) state_d = RUN;
        RUN: if (is_idle) begin
          if (IdleCycles == 0) state_d = SLEEP;
          else begin
            state_d = IDLE;
            idle_d  = IdleLoad;
          end
        end
        IDLE: begin
          if (!is_idle)           state_d = RUN;
          else if (idle_q == '0)  state_d = SLEEP;
          else                    idle_d  = idle_q - 1'b1;
        end
        SLEEP: if (wake_any) state_d = RUN;
        default: state_d = OFF;
      endcase
    end
  end

  // Gate opens combinationally on a wake so the core sees the edge in the wake cycle.
  always_comb begin
    clk_en_o = 1'b0;
    unique case (state_q)
      RUN, IDLE: clk_en_o = 1'b1;
      SLEEP:     clk_en_o = wake_any | halt_q;
      default:   clk_en_o = 1'b0;
    endcase
    core_sleep_o = (state_q == SLEEP) & ~clk_en_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fe_q   <= 1'b0;
      halt_q <= 1'b0;
    end else if (state_d == OFF) begin
      fe_q   <= 1'b0;
      halt_q <= 1'b0;
    end else if (state_q == OFF) begin
      fe_q   <= 1'b1;
      halt_q <= 1'b0;
    end else if (!StickyFetchEn) begin
      fe_q   <= fetch_enable_i;
      halt_q <= ~fetch_enable_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wv_q    <= 1'b0;
      cause_q <= '0;
      cnt_q   <= '0;
    end else begin
      wv_q <= wake_exit;
      if (wake_exit) cause_q <= {irq_nm_i, debug_req_i, wake_i & wake_mask_i};
      if (state_q == SLEEP) begin
        if (~&cnt_q) cnt_q <= cnt_q + 1'b1;
      end else if (state_d == SLEEP) begin
        cnt_q <= '0;
      end
    end
  end

  assign fetch_enable_o = fe_q;
  assign sleep_state_o  = state_q;
  assign wake_valid_o   = wv_q;
  assign wake_cause_o   = cause_q;
  assign sleep_cycles_o = cnt_q;

endmodule
